// File: rtl/rv_pipe_ctrl_if.sv
// Control bundle between the alu1 front stage and the pipeline sequencing controller.
// The master side drives the hazard/event sources; the slave side (controller) returns stall/flush/redirect.
interface rv_pipe_ctrl_if #(
   parameter int unsigned IADDR_SPACE_BITS = 32
);
   logic                        i_dec_valid;
   logic [4:0]                  i_dec_rs1;
   logic [4:0]                  i_dec_rs2;
   logic                        i_alu1_valid;
   logic [4:0]                  i_alu1_rd;
   logic                        i_alu1_load;
   logic                        i_alu1_inst_jal_jalr;
   logic                        i_alu1_inst_branch;
   logic                        i_alu1_branch_pred;
   logic                        i_alu1_branch_taken;
   logic [IADDR_SPACE_BITS-1:0] i_alu1_pc;
   logic [IADDR_SPACE_BITS-1:0] i_alu1_pc_next;
   logic [IADDR_SPACE_BITS-1:0] i_alu1_pc_target;
   logic                        i_alu1_to_trap;
   logic [IADDR_SPACE_BITS-1:0] i_trap_vec;
   logic                        i_retire_empty;
   logic                        i_mem_busy;

   logic                        o_stall_fetch;
   logic                        o_stall_decode;
   logic                        o_stall_alu1;
   logic                        o_flush_decode;
   logic                        o_flush_alu1;
   logic                        o_pc_redirect;
   logic [IADDR_SPACE_BITS-1:0] o_pc_redirect_addr;
   logic                        o_trap_enter;
   logic [IADDR_SPACE_BITS-1:0] o_mepc;
   logic                        o_drain_timeout;

   modport master (
      output i_dec_valid, i_dec_rs1, i_dec_rs2, i_alu1_valid, i_alu1_rd, i_alu1_load,
             i_alu1_inst_jal_jalr, i_alu1_inst_branch, i_alu1_branch_pred, i_alu1_branch_taken,
             i_alu1_pc, i_alu1_pc_next, i_alu1_pc_target, i_alu1_to_trap, i_trap_vec,
             i_retire_empty, i_mem_busy,
      input  o_stall_fetch, o_stall_decode, o_stall_alu1, o_flush_decode, o_flush_alu1,
             o_pc_redirect, o_pc_redirect_addr, o_trap_enter, o_mepc, o_drain_timeout
   );

   modport slave (
      input  i_dec_valid, i_dec_rs1, i_dec_rs2, i_alu1_valid, i_alu1_rd, i_alu1_load,
             i_alu1_inst_jal_jalr, i_alu1_inst_branch, i_alu1_branch_pred, i_alu1_branch_taken,
             i_alu1_pc, i_alu1_pc_next, i_alu1_pc_target, i_alu1_to_trap, i_trap_vec,
             i_retire_empty, i_mem_busy,
      output o_stall_fetch, o_stall_decode, o_stall_alu1, o_flush_decode, o_flush_alu1,
             o_pc_redirect, o_pc_redirect_addr, o_trap_enter, o_mepc, o_drain_timeout
   );
endinterface

// File: rtl/rv_pipe_ctrl.sv
// Pipeline sequencing controller for alu1: load-use bubbles, mispredict redirects and
// trap entry through a drain phase that waits for older instructions to retire.
module rv_pipe_ctrl #(
   parameter int unsigned IADDR_SPACE_BITS = 32,
   parameter int unsigned LOAD_USE_STALL   = 1,
   parameter int unsigned DRAIN_TIMEOUT    = 15
) (
   input  logic          i_clk,
   input  logic          i_reset,
   rv_pipe_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN,
      LU_STALL,
      DRAIN,
      TRAP_REDIR
   } state_t;

   localparam logic [7:0] LU_LAST    = 8'(LOAD_USE_STALL - 1);
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);

   state_t                      state;
   logic [7:0]                  cnt;
   logic [IADDR_SPACE_BITS-1:0] mepc_q;
   logic                        timeout_q;

   logic                        trap_hit;
   logic                        mispredict;
   logic                        load_use;
   logic [IADDR_SPACE_BITS-1:0] mp_target;

   logic                        stall_f, stall_d, stall_a;
   logic                        flush_d, flush_a;
   logic                        redirect;
   logic [IADDR_SPACE_BITS-1:0] redirect_addr;
   logic                        trap_enter;

   always_comb begin
      trap_hit   = bus.i_alu1_valid & bus.i_alu1_to_trap;
      mispredict = bus.i_alu1_valid &
                   ((bus.i_alu1_inst_branch & (bus.i_alu1_branch_taken != bus.i_alu1_branch_pred)) |
                    (bus.i_alu1_inst_jal_jalr & ~bus.i_alu1_branch_pred));
      load_use   = bus.i_alu1_valid & bus.i_alu1_load & (bus.i_alu1_rd != 5'd0) & bus.i_dec_valid &
                   ((bus.i_alu1_rd == bus.i_dec_rs1) | (bus.i_alu1_rd == bus.i_dec_rs2));
      mp_target  = (bus.i_alu1_inst_jal_jalr | (bus.i_alu1_inst_branch & bus.i_alu1_branch_taken)) ?
                   bus.i_alu1_pc_target : bus.i_alu1_pc_next;
   end

   // TRAP_REDIR always completes in one cycle; every other state freezes while memory is busy.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= RUN;
         cnt       <= '0;
         mepc_q    <= '0;
         timeout_q <= 1'b0;
      end else if (state == TRAP_REDIR) begin
         state <= RUN;
      end else if (!bus.i_mem_busy) begin
         unique case (state)
            RUN: begin
               if (trap_hit) begin
                  mepc_q <= bus.i_alu1_pc;
                  cnt    <= '0;
                  state  <= DRAIN;
               end else if (!mispredict && load_use && (LOAD_USE_STALL > 1)) begin
                  cnt   <= 8'd1;
                  state <= LU_STALL;
               end
            end
            LU_STALL: begin
               if (cnt == LU_LAST) state <= RUN;
               else                cnt   <= cnt + 8'd1;
            end
            DRAIN: begin
               if (bus.i_retire_empty) begin
                  state <= TRAP_REDIR;
               end else if (cnt == DRAIN_LAST) begin
                  timeout_q <= 1'b1;
                  state     <= TRAP_REDIR;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   always_comb begin
      stall_f       = 1'b0;
      stall_d       = 1'b0;
      stall_a       = 1'b0;
      flush_d       = 1'b0;
      flush_a       = 1'b0;
      redirect      = 1'b0;
      redirect_addr = '0;
      trap_enter    = 1'b0;
      if (!i_reset) begin
         if (state == TRAP_REDIR) begin
            redirect      = 1'b1;
            redirect_addr = bus.i_trap_vec;
            trap_enter    = 1'b1;
            flush_d       = 1'b1;
            flush_a       = 1'b1;
         end else if (bus.i_mem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_a = 1'b1;
         end else begin
            unique case (state)
               RUN: begin
                  if (!trap_hit) begin
                     if (mispredict) begin
                        redirect      = 1'b1;
                        redirect_addr = mp_target;
                        flush_d       = 1'b1;
                        flush_a       = 1'b1;
                     end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_a = 1'b1;
                     end
                  end
               end
               LU_STALL: begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  flush_a = 1'b1;
               end
               DRAIN: begin
                  stall_f = 1'b1;
                  flush_d = 1'b1;
                  flush_a = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.o_stall_fetch      = stall_f;
   assign bus.o_stall_decode     = stall_d;
   assign bus.o_stall_alu1       = stall_a;
   assign bus.o_flush_decode     = flush_d;
   assign bus.o_flush_alu1       = flush_a;
   assign bus.o_pc_redirect      = redirect;
   assign bus.o_pc_redirect_addr = redirect_addr;
   assign bus.o_trap_enter       = trap_enter;
   assign bus.o_mepc             = mepc_q;
   assign bus.o_drain_timeout    = timeout_q;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Bench for rv_pipe_ctrl: directed scenarios followed by random traffic, all checked
// against an event-level reference model of the sequencing rules.
module tb_rv_pipe_ctrl;

   localparam int unsigned AW  = 32;
   localparam int unsigned LUS = 2;
   localparam int unsigned DTO = 4;

   logic i_clk = 1'b0;
   logic i_reset = 1'b1;
   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 i_clk = ~i_clk;

   rv_pipe_ctrl_if #(.IADDR_SPACE_BITS(AW)) bus ();

   rv_pipe_ctrl #(
      .IADDR_SPACE_BITS(AW),
      .LOAD_USE_STALL(LUS),
      .DRAIN_TIMEOUT(DTO)
   ) dut (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .bus(bus.slave)
   );

   // Reference model state: bubble cycles still owed, drain progress, pending trap redirect.
   int          m_lu_left;
   bit          m_draining;
   int          m_drain_done;
   bit          m_redir_next;
   logic [AW-1:0] m_mepc;
   bit          m_tmo;

   // Last sampled outputs for directed checks.
   logic s_sf, s_sd, s_sa, s_fd, s_fa, s_redir, s_trap;
   logic [AW-1:0] s_addr, s_mepc;
   logic s_tmo;

   task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit f_mispredict();
      return bus.i_alu1_valid &&
             ((bus.i_alu1_inst_branch && (bus.i_alu1_branch_taken != bus.i_alu1_branch_pred)) ||
              (bus.i_alu1_inst_jal_jalr && !bus.i_alu1_branch_pred));
   endfunction

   function automatic bit f_load_use();
      return bus.i_alu1_valid && bus.i_alu1_load && bus.i_alu1_rd != 0 && bus.i_dec_valid &&
             (bus.i_alu1_rd == bus.i_dec_rs1 || bus.i_alu1_rd == bus.i_dec_rs2);
   endfunction

   function automatic bit f_trap();
      return bus.i_alu1_valid && bus.i_alu1_to_trap;
   endfunction

   task automatic model_reset();
      m_lu_left = 0; m_draining = 0; m_drain_done = 0; m_redir_next = 0; m_mepc = '0; m_tmo = 0;
   endtask

   task automatic tick();
      bit e_sf, e_sd, e_sa, e_fd, e_fa, e_redir, e_trap;
      logic [AW-1:0] e_addr;
      @(negedge i_clk);
      if (i_reset) model_reset();
      {e_sf, e_sd, e_sa, e_fd, e_fa, e_redir, e_trap} = '0;
      e_addr = '0;
      if (!i_reset) begin
         if (m_redir_next) begin
            e_redir = 1; e_addr = bus.i_trap_vec; e_trap = 1; e_fd = 1; e_fa = 1;
         end else if (bus.i_mem_busy) begin
            e_sf = 1; e_sd = 1; e_sa = 1;
         end else if (m_draining) begin
            e_sf = 1; e_fd = 1; e_fa = 1;
         end else if (m_lu_left > 0) begin
            e_sf = 1; e_sd = 1; e_fa = 1;
         end else if (f_trap()) begin
            // trap detection cycle itself carries no control outputs
         end else if (f_mispredict()) begin
            e_redir = 1; e_fd = 1; e_fa = 1;
            e_addr = (bus.i_alu1_inst_jal_jalr || (bus.i_alu1_inst_branch && bus.i_alu1_branch_taken)) ?
                     bus.i_alu1_pc_target : bus.i_alu1_pc_next;
         end else if (f_load_use()) begin
            e_sf = 1; e_sd = 1; e_fa = 1;
         end
      end
      s_sf = bus.o_stall_fetch;  s_sd = bus.o_stall_decode; s_sa = bus.o_stall_alu1;
      s_fd = bus.o_flush_decode; s_fa = bus.o_flush_alu1;   s_redir = bus.o_pc_redirect;
      s_addr = bus.o_pc_redirect_addr; s_trap = bus.o_trap_enter;
      s_mepc = bus.o_mepc; s_tmo = bus.o_drain_timeout;
      chk("stall_fetch", AW'(s_sf), AW'(e_sf));
      chk("stall_decode", AW'(s_sd), AW'(e_sd));
      chk("stall_alu1", AW'(s_sa), AW'(e_sa));
      chk("flush_decode", AW'(s_fd), AW'(e_fd));
      chk("flush_alu1", AW'(s_fa), AW'(e_fa));
      chk("pc_redirect", AW'(s_redir), AW'(e_redir));
      chk("redirect_addr", s_addr, e_addr);
      chk("trap_enter", AW'(s_trap), AW'(e_trap));
      chk("mepc", s_mepc, m_mepc);
      chk("drain_timeout", AW'(s_tmo), AW'(m_tmo));
      @(posedge i_clk);
      if (i_reset) begin
         model_reset();
      end else if (m_redir_next) begin
         m_redir_next = 0;
      end else if (!bus.i_mem_busy) begin
         if (m_draining) begin
            m_drain_done++;
            if (bus.i_retire_empty) begin
               m_draining = 0; m_redir_next = 1;
            end else if (m_drain_done == int'(DTO)) begin
               m_draining = 0; m_redir_next = 1; m_tmo = 1;
            end
         end else if (m_lu_left > 0) begin
            m_lu_left--;
         end else if (f_trap()) begin
            m_mepc = bus.i_alu1_pc; m_draining = 1; m_drain_done = 0;
         end else if (!f_mispredict() && f_load_use()) begin
            m_lu_left = int'(LUS) - 1;
         end
      end
      #1;
   endtask

   task automatic idle();
      bus.i_dec_valid = 0; bus.i_dec_rs1 = '0; bus.i_dec_rs2 = '0;
      bus.i_alu1_valid = 0; bus.i_alu1_rd = '0; bus.i_alu1_load = 0;
      bus.i_alu1_inst_jal_jalr = 0; bus.i_alu1_inst_branch = 0;
      bus.i_alu1_branch_pred = 0; bus.i_alu1_branch_taken = 0;
      bus.i_alu1_pc = '0; bus.i_alu1_pc_next = '0; bus.i_alu1_pc_target = '0;
      bus.i_alu1_to_trap = 0; bus.i_trap_vec = '0; bus.i_retire_empty = 0; bus.i_mem_busy = 0;
   endtask

   initial begin
      int lu_cycles;
      int drain_cycles;
      bit seen;
      idle();
      model_reset();

      // Reset state
      tick();
      tick();
      i_reset = 0;
      tick();

      // Load-use rd=5 vs rs2=5: two bubble cycles
      lu_cycles = 0;
      bus.i_alu1_valid = 1; bus.i_alu1_load = 1; bus.i_alu1_rd = 5'd5;
      bus.i_dec_valid = 1; bus.i_dec_rs1 = 5'd1; bus.i_dec_rs2 = 5'd5;
      tick(); lu_cycles += int'(s_sd && s_sf && s_fa);
      bus.i_alu1_valid = 0;
      tick(); lu_cycles += int'(s_sd && s_sf && s_fa);
      tick(); lu_cycles += int'(s_sd && s_sf && s_fa);
      chk("lu_len", AW'(lu_cycles), AW'(2));
      // rd=0 never stalls
      bus.i_alu1_valid = 1; bus.i_alu1_rd = 5'd0; bus.i_dec_rs2 = 5'd0;
      tick();
      chk("lu_rd0", AW'(s_sd), '0);
      idle();

      // Mispredict not-taken, then taken
      bus.i_alu1_valid = 1; bus.i_alu1_inst_branch = 1; bus.i_alu1_branch_pred = 1;
      bus.i_alu1_branch_taken = 0; bus.i_alu1_pc_next = 32'h104; bus.i_alu1_pc_target = 32'h300;
      tick();
      chk("mp_nt_addr", s_addr, 32'h104);
      bus.i_alu1_branch_pred = 0; bus.i_alu1_branch_taken = 1; bus.i_alu1_pc_target = 32'h200;
      tick();
      chk("mp_t_addr", s_addr, 32'h200);
      idle();
      tick();

      // jal predicted not-taken redirects; predicted taken does not
      bus.i_alu1_valid = 1; bus.i_alu1_inst_jal_jalr = 1; bus.i_alu1_pc_target = 32'h80;
      tick();
      chk("jal_addr", s_addr, 32'h80);
      bus.i_alu1_branch_pred = 1;
      tick();
      chk("jal_pred_redir", AW'(s_redir), '0);
      idle();

      // Trap at 0x40, retire empty on third drain cycle
      bus.i_alu1_valid = 1; bus.i_alu1_to_trap = 1; bus.i_alu1_pc = 32'h40; bus.i_trap_vec = 32'h100;
      tick();
      bus.i_alu1_valid = 0; bus.i_alu1_to_trap = 0;
      drain_cycles = 0;
      tick(); drain_cycles += int'(s_sf && s_fd && s_fa);
      tick(); drain_cycles += int'(s_sf && s_fd && s_fa);
      bus.i_retire_empty = 1;
      tick(); drain_cycles += int'(s_sf && s_fd && s_fa);
      chk("drain_len", AW'(drain_cycles), AW'(3));
      tick();
      chk("trap_addr", s_addr, 32'h100);
      chk("trap_enter", AW'(s_trap), AW'(1));
      chk("trap_mepc", s_mepc, 32'h40);
      chk("trap_no_tmo", AW'(s_tmo), '0);
      bus.i_retire_empty = 0;
      tick();

      // Drain timeout with retire never empty
      bus.i_alu1_valid = 1; bus.i_alu1_to_trap = 1; bus.i_alu1_pc = 32'h44; bus.i_trap_vec = 32'h180;
      tick();
      bus.i_alu1_valid = 0; bus.i_alu1_to_trap = 0;
      drain_cycles = 0; seen = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
         tick();
         if (s_trap) seen = 1;
         else drain_cycles += int'(s_sf && s_fd && s_fa);
      end
      chk("tmo_redirect_seen", AW'(seen), AW'(1));
      chk("tmo_drain_len", AW'(drain_cycles), AW'(4));
      chk("tmo_flag", AW'(s_tmo), AW'(1));
      tick(); tick();
      chk("tmo_sticky", AW'(s_tmo), AW'(1));

      // Memory busy during a mispredict delays the redirect
      bus.i_alu1_valid = 1; bus.i_alu1_inst_branch = 1; bus.i_alu1_branch_pred = 1;
      bus.i_alu1_pc_next = 32'h504; bus.i_mem_busy = 1;
      tick();
      chk("busy_redir", AW'(s_redir), '0);
      chk("busy_stall", AW'(s_sa), AW'(1));
      bus.i_mem_busy = 0;
      tick();
      chk("busy_release_addr", s_addr, 32'h504);
      idle();

      // Reset during drain
      bus.i_alu1_valid = 1; bus.i_alu1_to_trap = 1; bus.i_alu1_pc = 32'h60;
      tick();
      idle();
      tick();
      i_reset = 1;
      tick();
      chk("rst_flush", AW'(s_fa), '0);
      chk("rst_tmo", AW'(s_tmo), '0);
      i_reset = 0;
      tick();
      chk("rst_run", AW'(s_fa), '0);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         bus.i_dec_valid = 1'($urandom);
         bus.i_dec_rs1 = 5'($urandom_range(0, 3));
         bus.i_dec_rs2 = 5'($urandom_range(0, 3));
         bus.i_alu1_valid = 1'($urandom);
         bus.i_alu1_rd = 5'($urandom_range(0, 3));
         bus.i_alu1_load = 1'($urandom);
         bus.i_alu1_inst_jal_jalr = ($urandom_range(0, 5) == 0);
         bus.i_alu1_inst_branch = ($urandom_range(0, 2) == 0);
         bus.i_alu1_branch_pred = 1'($urandom);
         bus.i_alu1_branch_taken = 1'($urandom);
         bus.i_alu1_pc = $urandom;
         bus.i_alu1_pc_next = $urandom;
         bus.i_alu1_pc_target = $urandom;
         bus.i_alu1_to_trap = ($urandom_range(0, 12) == 0);
         bus.i_trap_vec = $urandom;
         bus.i_retire_empty = ($urandom_range(0, 3) == 0);
         bus.i_mem_busy = ($urandom_range(0, 4) == 0);
         i_reset = ($urandom_range(0, 99) == 0);
         tick();
      end
      i_reset = 0;
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_pipe_ctrl.md
Name: rv_pipe_ctrl

Overview:
Pipeline sequencing controller for the execute front (alu1) stage. Generates stall, flush and PC-redirect controls for fetch, decode and alu1 from three event sources: load-use hazards, branch/jump mispredicts and trap entry. Trap entry uses a drain state machine that waits for older instructions to retire before redirecting to the trap vector.

Parameters:
IADDR_SPACE_BITS, 32, instruction address width.
LOAD_USE_STALL, 1, load-use bubble length in cycles; legal range 1..3.
DRAIN_TIMEOUT, 15, maximum cycles spent in DRAIN before a forced redirect; legal range 1..255.

Ports:
i_clk  in  1  clock, rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_dec_valid  in  1  decode stage holds a valid instruction.
i_dec_rs1  in  5  decode source register 1.
i_dec_rs2  in  5  decode source register 2.
i_alu1_valid  in  1  alu1 stage holds a valid instruction.
i_alu1_rd  in  5  alu1 destination register.
i_alu1_load  in  1  alu1 instruction is a load (result comes from memory).
i_alu1_inst_jal_jalr  in  1  jal, jalr or mret in alu1.
i_alu1_inst_branch  in  1  conditional branch in alu1.
i_alu1_branch_pred  in  1  predicted-taken flag carried with the instruction.
i_alu1_branch_taken  in  1  resolved branch condition.
i_alu1_pc  in  IADDR_SPACE_BITS  alu1 PC.
i_alu1_pc_next  in  IADDR_SPACE_BITS  fall-through PC.
i_alu1_pc_target  in  IADDR_SPACE_BITS  computed target.
i_alu1_to_trap  in  1  alu1 instruction raises a trap.
i_trap_vec  in  IADDR_SPACE_BITS  trap handler address.
i_retire_empty  in  1  all stages older than alu1 are empty.
i_mem_busy  in  1  memory stage cannot accept; freezes the pipe.
o_stall_fetch  out  1  hold fetch.
o_stall_decode  out  1  hold decode.
o_stall_alu1  out  1  hold alu1 registers.
o_flush_decode  out  1  clear the decode stage register.
o_flush_alu1  out  1  load a bubble into alu1 (drives alu1 i_flush).
o_pc_redirect  out  1  single-cycle redirect strobe.
o_pc_redirect_addr  out  IADDR_SPACE_BITS  redirect target.
o_trap_enter  out  1  single-cycle strobe on the trap redirect.
o_mepc  out  IADDR_SPACE_BITS  captured trapping PC, valid with o_trap_enter.
o_drain_timeout  out  1  sticky flag: a drain timed out; cleared only by reset.

Behaviour:
- States: RUN, LU_STALL, DRAIN, TRAP_REDIR. Reset state is RUN. All counters and o_mepc reset to 0. All outputs are 0 while i_reset is high.
- Priority in RUN:
  1. i_mem_busy
  2. trap
  3. mispredict
  4. load-use
- i_mem_busy, any state except TRAP_REDIR:
  - Assert o_stall_fetch, o_stall_decode and o_stall_alu1; no flush, no redirect.
  - State and counters freeze.
  - alu1 events are not evaluated that cycle.
- Trap (RUN, i_alu1_valid & i_alu1_to_trap):
  - Capture i_alu1_pc into o_mepc.
  - Go to DRAIN; drain counter = 0.
- DRAIN:
  - Each cycle assert o_stall_fetch, o_flush_decode and o_flush_alu1. Younger work is discarded.
  - Counter increments per non-busy cycle.
  - Exit to TRAP_REDIR when i_retire_empty = 1, or when counter == DRAIN_TIMEOUT-1. A timeout exit also sets o_drain_timeout.
- TRAP_REDIR, exactly one cycle, then RUN:
  - o_pc_redirect = 1, o_pc_redirect_addr = i_trap_vec, o_trap_enter = 1.
  - o_flush_decode and o_flush_alu1 asserted.
  - i_mem_busy is ignored.
- Mispredict (RUN, i_alu1_valid, combinational same cycle):
  - Condition: (i_alu1_inst_branch & (i_alu1_branch_taken != i_alu1_branch_pred)) | (i_alu1_inst_jal_jalr & !i_alu1_branch_pred).
  - Response: o_pc_redirect = 1, o_flush_decode = 1, o_flush_alu1 = 1.
  - o_pc_redirect_addr = i_alu1_pc_target if the instruction is jal/jalr or the branch is taken; otherwise i_alu1_pc_next.
  - Stays in RUN. A simultaneous load-use condition is discarded, because the dependent instruction is flushed.
- Load-use (RUN, i_alu1_valid & i_alu1_load & i_alu1_rd != 0 & i_dec_valid & (rd == rs1 | rd == rs2)):
  - Assert o_stall_fetch, o_stall_decode and o_flush_alu1 this cycle.
  - If LOAD_USE_STALL > 1, enter LU_STALL with counter = 1.
- LU_STALL:
  - Same three outputs held.
  - Return to RUN when counter == LOAD_USE_STALL-1.
  - The alu1 bubble has valid = 0, so the hazard cannot re-trigger.
- When no event is active, all outputs are 0 and o_pc_redirect_addr = 0.
- Asynchronous reset mid-DRAIN or mid-LU_STALL returns to RUN immediately. o_drain_timeout is cleared.

Test Plan:
- Load-use: alu1 load rd=5, decode rs2=5, LOAD_USE_STALL=2 -> stall_fetch/stall_decode/flush_alu1 high exactly 2 cycles, then 0. Repeat with rd=0 -> no stall.
- Mispredict not-taken: branch pred=1, taken=0, pc_next=0x104 -> one-cycle redirect to 0x104 with both flushes. Mispredict taken: pred=0, taken=1, target=0x200 -> redirect to 0x200.
- jal with pred=0, target=0x80 -> redirect to 0x80. jal with pred=1 -> no redirect.
- Trap at pc=0x40, i_retire_empty rising after 3 cycles, trap_vec=0x100 -> 3 DRAIN cycles, then one cycle of redirect to 0x100 with trap_enter=1 and mepc=0x40; o_drain_timeout stays 0.
- Trap with i_retire_empty stuck at 0, DRAIN_TIMEOUT=4 -> redirect after 4 DRAIN cycles; o_drain_timeout=1 and sticky until reset.
- Simultaneous events: i_mem_busy during a mispredict -> full stall, no redirect; redirect occurs on the first non-busy cycle. Reset asserted during DRAIN -> all outputs 0 immediately, RUN after release.
